// File: rtl/ysyx_24090013_imem.sv
// NPC instruction-memory responder: one outstanding word fetch, fixed latency, backdoor preload.
// Optional YSYX_24090013_IMEM_RANDLAT_EN adds 0..3 cycles of LFSR-driven latency jitter.
module ysyx_24090013_imem #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [31:0]           i_req_addr,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_data,
  output logic                  o_rsp_err,
  input  logic                  i_ld_en,
  input  logic [DEPTH_LOG2-1:0] i_ld_idx,
  input  logic [31:0]           i_ld_data
);
  localparam int          DEPTH       = 1 << DEPTH_LOG2;
  localparam int          CNT_W       = 5;
  localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next, w_cnt_load;
  logic [DEPTH_LOG2-1:0] r_idx, w_req_idx, w_cap_idx;
  logic                  r_err, w_req_err, w_cap_err, w_capture;
  logic [31:0]           w_req_off;
  logic [31:0]           r_rsp_data;
  logic                  r_rsp_err;
  logic [31:0]           r_mem [DEPTH];

  // Wrapping subtraction makes addresses below the base land far out of range.
  assign w_req_off = i_req_addr - BASE_ADDR;
  assign w_req_idx = w_req_off[DEPTH_LOG2+1:2];
  assign w_req_err = (i_req_addr[1:0] != 2'b00) | ((w_req_off >> 2) >= DEPTH_WORDS);

`ifdef YSYX_24090013_IMEM_RANDLAT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_cnt_load = CNT_W'(LATENCY - 1) + {3'b000, r_lfsr[1:0]};
`else
  assign w_cnt_load = CNT_W'(LATENCY - 1);
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_cap_idx    = r_idx;
    w_cap_err    = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_cnt_next = w_cnt_load;
          if (w_cnt_load == '0) begin
            // Single-cycle latency: capture straight from the request address.
            w_state_next = S_RESP;
            w_capture    = 1'b1;
            w_cap_idx    = w_req_idx;
            w_cap_err    = w_req_err;
          end else begin
            w_state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_RESP;
          w_capture    = 1'b1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && i_req_valid) begin
        r_idx <= w_req_idx;
        r_err <= w_req_err;
      end
      // Reads the pre-edge array contents, so a same-cycle load returns the old word.
      if (w_capture) begin
        r_rsp_data <= w_cap_err ? 32'h0 : r_mem[w_cap_idx];
        r_rsp_err  <= w_cap_err;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ld_en) begin
      r_mem[i_ld_idx] <= i_ld_data;
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ysyx_24090013_imem.sv
// Directed plus randomized bench for ysyx_24090013_imem against an address-range memory model.
module tb_ysyx_24090013_imem;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DL2    = 12;
  localparam int          LAT    = 2;
  localparam int          NWORDS = 1 << DL2;
  localparam int          NPRE   = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           rsp_ready = 1'b0;
  logic           ld_en = 1'b0;
  logic [31:0]    req_addr = '0;
  logic [31:0]    ld_data = '0;
  logic [DL2-1:0] ld_idx = '0;
  logic           req_ready, rsp_valid, rsp_err;
  logic [31:0]    rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [31:0] model [NWORDS];

  ysyx_24090013_imem #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fault iff misaligned or outside [BASE, BASE + 4*NWORDS).
  function automatic logic exp_err(input logic [31:0] a);
    longint ua, lo, hi;
    ua = a;
    lo = BASE;
    hi = lo + 4 * NWORDS;
    return (a[1:0] != 2'b00) || (ua < lo) || (ua >= hi);
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = DL2'(idx); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model[idx] = d;
  endtask

  // Entered and left on a negedge. stall = cycles rsp_ready held low after rsp_valid.
  task automatic fetch(input logic [31:0] addr, input int stall, input bit collide,
                       input logic [31:0] new_word);
    int n, lat, idx;
    logic [31:0] ed;
    logic ee;
    ee  = exp_err(addr);
    idx = ee ? 0 : int'((addr - BASE) >> 2);
    ed  = ee ? 32'h0 : model[idx];
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    req_valid = 1'b0; req_addr = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      ld_en = 1'b0;
      if (collide && lat == 1 && !rsp_valid) begin
        ld_en = 1'b1; ld_idx = DL2'(idx); ld_data = new_word;
      end
    end while (!rsp_valid && lat < 40);
    ld_en = 1'b0;
    if (collide) model[idx] = new_word;
`ifdef YSYX_24090013_IMEM_RANDLAT_EN
    check("latency_in_range", {31'b0, (lat >= LAT && lat <= LAT + 3)}, 32'd1);
`else
    check("latency", lat, LAT);
`endif
    check("rsp_data", rsp_data, ed);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, ee});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, ed);
      check("stall_err", {31'b0, rsp_err}, {31'b0, ee});
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
    $display("fetch addr=%h lat=%0d data=%h err=%0d exp_data=%h exp_err=%0d",
             addr, lat, rsp_data, rsp_err, ed, ee);
  endtask

  initial begin
    int prev, n;
    logic [31:0] a;
    for (int i = 0; i < NWORDS; i++) model[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    load(0, 32'h0000_0413);
    load(1, 32'h0010_0073);
    for (int i = 2; i < NPRE; i++) load(i, $urandom);
    load(NWORDS - 1, 32'hCAFE_F00D);

    // Basic, backpressure, faults, last valid word
    fetch(BASE, 0, 1'b0, 32'h0);
    fetch(BASE + 32'd4, 3, 1'b0, 32'h0);
    fetch(BASE + 32'd2, 0, 1'b0, 32'h0);
    fetch(32'h7FFF_FFFC, 0, 1'b0, 32'h0);
    fetch(32'h8000_4000, 1, 1'b0, 32'h0);
    fetch(32'h8000_3FFC, 0, 1'b0, 32'h0);

    // PC stream: accepts spaced LAT+1 apart with rsp_ready returned promptly
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      fetch(BASE + 32'(4 * k), 0, 1'b0, 32'h0);
`ifndef YSYX_24090013_IMEM_RANDLAT_EN
      if (k > 0) check("stream_spacing", accept_cyc - prev, LAT + 1);
`endif
      prev = accept_cyc;
    end

    // Reset during BUSY
    req_valid = 1'b1; req_addr = BASE + 32'd8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("busy_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("busy_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("busy_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    fetch(BASE + 32'd12, 0, 1'b0, 32'h0);

    // Reset during RESP
    req_valid = 1'b1; req_addr = BASE + 32'd16;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    check("resp_reached", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("resp_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("resp_rst_rsp_data", rsp_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("resp_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    fetch(BASE + 32'd16, 0, 1'b0, 32'h0);

`ifndef YSYX_24090013_IMEM_RANDLAT_EN
    // Load colliding with the capture edge: old word now, new word on re-fetch
    if (LAT >= 2) begin
      fetch(BASE + 32'd20, 0, 1'b1, 32'hDEAD_BEEF);
      fetch(BASE + 32'd20, 0, 1'b0, 32'h0);
    end
`endif

    // Randomized mix of good and faulting addresses
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        7:       a = BASE + 32'(4 * $urandom_range(0, NPRE - 1)) + 32'($urandom_range(1, 3));
        8:       a = BASE - 32'(4 * $urandom_range(1, 1000));
        9:       a = BASE + 32'(4 * NWORDS) + 32'(4 * $urandom_range(0, 1000));
        default: a = BASE + 32'(4 * $urandom_range(0, NPRE - 1));
      endcase
      fetch(a, int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
